// File: rtl/micro_sequencer.sv
// RV32I control unit with a built-in micro-sequencer for the custom UMUL
// (iterative multiply) and MEMC (word-by-word memory copy) instructions.
// Every control output is registered; stall holds PC/IR while a multi-cycle
// op is in flight. Handshake: an instruction is taken on a rising edge when
// instr_valid=1 and stall=0; a memory access completes on a rising edge
// where mem_ready=1, otherwise the sequencer holds its outputs unchanged.
module micro_sequencer #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 4,
   parameter int MAX_COPY   = 16,
   parameter int CNT_W      = $clog2(MAX_COPY + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] instr,
   input  logic             instr_valid,
   input  logic             zero,
   input  logic [CNT_W-1:0] copy_len,
   input  logic             mem_ready,
   output logic             reg_write_en,
   output logic             data_write_en,
   output logic             alu_src_1,
   output logic             alu_src_2,
   output logic [3:0]       alu_control,
   output logic [1:0]       result_src,
   output logic [1:0]       pc_src,
   output logic [1:0]       imm_src,
   output logic [2:0]       ls_src,
   output logic             stall,
   output logic             busy,
   output logic [CNT_W-1:0] mc_offset,
   output logic             illegal
);

   localparam int MC_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_COPY);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_UMUL = 4'b1010;

   localparam logic [2:0] LS_WORD = 3'b010;

   typedef enum logic [1:0] {IDLE, MUL, COPY_RD, COPY_WR} state_t;

   state_t           state, state_n;
   logic [MC_W-1:0]  cnt, cnt_n;
   logic [CNT_W-1:0] idx, idx_n;
   logic [CNT_W-1:0] len, len_n;
   logic [CNT_W-1:0] len_clamp;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;

   // decoded fields for single-cycle instructions
   logic       d_rwe, d_dwe, d_a1, d_a2, d_branch;
   logic [3:0] d_alu;
   logic [1:0] d_rs, d_pc, d_imm;
   logic [2:0] d_ls;
   logic       d_illegal, d_umul, d_memc;

   // next values of the registered outputs
   logic             rwe_n, dwe_n, a1_n, a2_n, stall_n, busy_n, illegal_n;
   logic [3:0]       alu_n;
   logic [1:0]       rs_n, pc_n, imm_n;
   logic [2:0]       ls_n;
   logic [CNT_W-1:0] off_n;

   assign opcode    = instr[6:0];
   assign f3        = instr[14:12];
   assign f7        = instr[31:25];
   assign len_clamp = (copy_len > MAX_LEN) ? MAX_LEN : copy_len;

   // alt selects SUB/SRA (funct7 bit 5) where the encoding allows it
   function automatic logic [3:0] alu_sel(input logic [2:0] fn3, input logic alt);
      case (fn3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // instruction decode into a single-cycle control word plus classification
   always_comb begin
      d_rwe = 1'b0; d_dwe = 1'b0; d_a1 = 1'b0; d_a2 = 1'b0; d_branch = 1'b0;
      d_alu = 4'b0000; d_rs = 2'b00; d_pc = 2'b00; d_imm = 2'b00; d_ls = 3'b000;
      d_illegal = 1'b0; d_umul = 1'b0; d_memc = 1'b0;
      case (opcode)
         7'b0110011: begin // R-type ALU
            d_rwe = 1'b1;
            d_alu = alu_sel(f3, f7[5]);
            if (!(f7 == 7'b0000000 ||
                  (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
               d_illegal = 1'b1;
         end
         7'b0010011: begin // I-type ALU; only SRAI may use funct7 bit 5
            d_rwe = 1'b1;
            d_a2  = 1'b1;
            d_alu = alu_sel(f3, (f3 == 3'b101) && f7[5]);
            if ((f3 == 3'b001 && f7 != 7'b0000000) ||
                (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000))
               d_illegal = 1'b1;
         end
         7'b0000011: begin // loads
            d_rwe = 1'b1; d_a2 = 1'b1; d_alu = ALU_ADD; d_rs = 2'b01; d_ls = f3;
            if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) d_illegal = 1'b1;
         end
         7'b0100011: begin // stores
            d_dwe = 1'b1; d_a2 = 1'b1; d_alu = ALU_ADD; d_imm = 2'b01; d_ls = f3;
            if (f3[2] || f3 == 3'b011) d_illegal = 1'b1;
         end
         7'b1100011: begin // branches; zero comes from the ALU compare
            d_branch = 1'b1; d_alu = ALU_SUB; d_imm = 2'b10;
            if (f3 == 3'b010 || f3 == 3'b011) d_illegal = 1'b1;
         end
         7'b1101111: begin // JAL: target = PC + J-imm (extender tells J from U by instr[3])
            d_rwe = 1'b1; d_a1 = 1'b1; d_a2 = 1'b1; d_alu = ALU_ADD;
            d_rs = 2'b10; d_pc = 2'b01; d_imm = 2'b11;
         end
         7'b1100111: begin // JALR
            d_rwe = 1'b1; d_a2 = 1'b1; d_alu = ALU_ADD; d_rs = 2'b10; d_pc = 2'b10;
            if (f3 != 3'b000) d_illegal = 1'b1;
         end
         7'b0110111: begin // LUI
            d_rwe = 1'b1; d_a2 = 1'b1; d_alu = ALU_ADD; d_imm = 2'b11;
         end
         7'b0010111: begin // AUIPC
            d_rwe = 1'b1; d_a1 = 1'b1; d_a2 = 1'b1; d_alu = ALU_ADD; d_imm = 2'b11;
         end
         7'b0110000: begin // UMUL
            if (f3 == 3'b000 && f7 == 7'b0000000) d_umul = 1'b1;
            else d_illegal = 1'b1;
         end
         7'b0000000: begin // MEMC
            if (f3 == 3'b000) d_memc = 1'b1;
            else d_illegal = 1'b1;
         end
         7'b0001111: begin // FENCE: nothing to order here, issue a NOP
         end
         7'b1110011: begin // only ECALL/EBREAK; both issue a NOP
            if (instr[31:7] != 25'h0000000 && instr[31:7] != 25'h0002000)
               d_illegal = 1'b1;
         end
         default: d_illegal = 1'b1;
      endcase
   end

   // next state and next registered control word
   always_comb begin
      state_n = state; cnt_n = cnt; idx_n = idx; len_n = len;
      rwe_n = 1'b0; dwe_n = 1'b0; a1_n = 1'b0; a2_n = 1'b0;
      alu_n = 4'b0000; rs_n = 2'b00; pc_n = 2'b00; imm_n = 2'b00; ls_n = 3'b000;
      stall_n = 1'b0; busy_n = 1'b0; illegal_n = 1'b0; off_n = '0;
      case (state)
         IDLE: begin
            if (instr_valid) begin
               if (d_illegal) begin
                  illegal_n = 1'b1;
               end else if (d_umul) begin
                  alu_n = ALU_UMUL;
                  if (MUL_CYCLES > 1) begin
                     state_n = MUL;
                     cnt_n   = MC_W'(MUL_CYCLES - 1);
                     stall_n = 1'b1;
                     busy_n  = 1'b1;
                  end else begin
                     rwe_n = 1'b1;
                  end
               end else if (d_memc) begin
                  // a zero-length copy falls through as a NOP
                  if (len_clamp != '0) begin
                     state_n = COPY_RD;
                     idx_n   = '0;
                     len_n   = len_clamp;
                     rs_n    = 2'b01;
                     ls_n    = LS_WORD;
                     stall_n = 1'b1;
                     busy_n  = 1'b1;
                  end
               end else begin
                  rwe_n = d_rwe; dwe_n = d_dwe; a1_n = d_a1; a2_n = d_a2;
                  alu_n = d_alu; rs_n = d_rs; imm_n = d_imm; ls_n = d_ls;
                  pc_n  = d_branch ? (zero ? 2'b01 : 2'b00) : d_pc;
               end
            end
         end
         MUL: begin
            alu_n = ALU_UMUL;
            if (cnt == MC_W'(1)) begin
               state_n = IDLE;
               rwe_n   = 1'b1;
            end else begin
               cnt_n   = cnt - MC_W'(1);
               stall_n = 1'b1;
               busy_n  = 1'b1;
            end
         end
         COPY_RD: begin
            rs_n = 2'b01; ls_n = LS_WORD; off_n = idx;
            stall_n = 1'b1; busy_n = 1'b1;
            if (mem_ready) begin
               state_n = COPY_WR;
               dwe_n   = 1'b1;
            end
         end
         COPY_WR: begin
            if (!mem_ready) begin
               dwe_n = 1'b1; rs_n = 2'b01; ls_n = LS_WORD; off_n = idx;
               stall_n = 1'b1; busy_n = 1'b1;
            end else if ({1'b0, idx} + 1'b1 == {1'b0, len}) begin
               state_n = IDLE;
            end else begin
               state_n = COPY_RD;
               idx_n   = idx + 1'b1;
               rs_n = 2'b01; ls_n = LS_WORD; off_n = idx + 1'b1;
               stall_n = 1'b1; busy_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // state and output registers; reset aborts any op in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE; cnt <= '0; idx <= '0; len <= '0;
         reg_write_en <= 1'b0; data_write_en <= 1'b0;
         alu_src_1 <= 1'b0; alu_src_2 <= 1'b0; alu_control <= 4'b0000;
         result_src <= 2'b00; pc_src <= 2'b00; imm_src <= 2'b00; ls_src <= 3'b000;
         stall <= 1'b0; busy <= 1'b0; mc_offset <= '0; illegal <= 1'b0;
      end else begin
         state <= state_n; cnt <= cnt_n; idx <= idx_n; len <= len_n;
         reg_write_en <= rwe_n; data_write_en <= dwe_n;
         alu_src_1 <= a1_n; alu_src_2 <= a2_n; alu_control <= alu_n;
         result_src <= rs_n; pc_src <= pc_n; imm_src <= imm_n; ls_src <= ls_n;
         stall <= stall_n; busy <= busy_n; mc_offset <= off_n; illegal <= illegal_n;
      end
   end

endmodule
